// File: rtl/period_meter.sv
// Measures the rising-edge-to-rising-edge period of an asynchronous pulse in clk cycles.
// Short glitch edges are rejected, and a timeout is flagged when edges stop arriving.
module period_meter #(
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int COUNT_WIDTH                 = 32,
  parameter int TIMEOUT_COUNT               = 200_000_000,
  parameter int MIN_PERIOD                  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   pulseIn,
  output logic [COUNT_WIDTH-1:0] periodOut,
  output logic                   periodValid,
  output logic                   timeout,
  output logic                   locked
);

  // Elaboration-time guard on parameter ranges the counter logic relies on.
  if ((64'(TIMEOUT_COUNT) >= (64'd1 << COUNT_WIDTH)) || (MIN_PERIOD < 1) ||
      (BOARD_CLOCK_FREQUENCY_IN_HZ < 1)) begin : g_bad_params
    $error("period_meter: illegal parameter combination");
  end

  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_COUNT);
  localparam logic [COUNT_WIDTH-1:0] MIN_VAL     = COUNT_WIDTH'(MIN_PERIOD);
  localparam logic [COUNT_WIDTH-1:0] ONE         = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURING,
    TIMEOUT
  } state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] counter;
  logic                   sync1, sync2, hist;
  logic                   pulse_edge;

  // NOTE: flops are written with non-blocking assignments so every register
  // samples the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= pulseIn;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign pulse_edge = sync2 & ~hist;

  // An accepted edge always beats the timeout check, so a period exactly equal
  // to TIMEOUT_COUNT is still reported rather than flagged as a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      periodOut   <= '0;
      periodValid <= 1'b0;
      timeout     <= 1'b0;
      locked      <= 1'b0;
    end else begin
      periodValid <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        counter <= '0;
        timeout <= 1'b0;
        locked  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            counter <= '0;
            state   <= ARMED;
          end
          ARMED: begin
            if (pulse_edge) begin
              state   <= MEASURING;
              counter <= ONE;
            end else if (counter == TIMEOUT_VAL) begin
              state   <= TIMEOUT;
              timeout <= 1'b1;
            end else begin
              counter <= counter + ONE;
            end
          end
          MEASURING: begin
            if (pulse_edge && (counter >= MIN_VAL)) begin
              periodOut   <= counter;
              periodValid <= 1'b1;
              locked      <= 1'b1;
              counter     <= ONE;
            end else if (counter == TIMEOUT_VAL) begin
              state   <= TIMEOUT;
              timeout <= 1'b1;
              locked  <= 1'b0;
            end else begin
              counter <= counter + ONE;
            end
          end
          TIMEOUT: begin
            if (pulse_edge) begin
              state   <= MEASURING;
              counter <= ONE;
              timeout <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: steady pulses, glitch rejection, timeout,
// the TIMEOUT_COUNT boundary, and reset/disable in the middle of a period.
module tb_period_meter;

  localparam int CW = 16;
  localparam int TO = 1000;
  localparam int MP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          pulseIn;
  logic [CW-1:0] periodOut;
  logic          periodValid;
  logic          timeout;
  logic          locked;

  int tests = 0;
  int fails = 0;
  int valid_count = 0;
  int back_to_back = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  period_meter #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(100_000_000),
    .COUNT_WIDTH(CW),
    .TIMEOUT_COUNT(TO),
    .MIN_PERIOD(MP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .pulseIn(pulseIn),
    .periodOut(periodOut),
    .periodValid(periodValid),
    .timeout(timeout),
    .locked(locked)
  );

  always @(negedge clk) begin
    if (periodValid) valid_count <= valid_count + 1;
    if (periodValid && prev_valid) back_to_back <= back_to_back + 1;
    prev_valid <= periodValid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; pulseIn = 1'b0;
    #1;
    tests++; if (periodOut !== 16'd0) begin fails++; $display("FAIL reset_periodOut: got %0d expected 0", periodOut); end
    tests++; if (periodValid !== 1'b0) begin fails++; $display("FAIL reset_periodValid: got %b expected 0", periodValid); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b expected 0", locked); end
    tick(3);
    rst = 1'b0;
    tick(2);
    tests++; if ({periodValid, timeout, locked} !== 3'b000) begin fails++; $display("FAIL idle_flags: got %b expected 000", {periodValid, timeout, locked}); end
  endtask

  task automatic test_steady;
    enable = 1'b1;
    tick(5);
    pulseIn = 1'b1; tick(3);
    tests++; if (periodValid !== 1'b0) begin fails++; $display("FAIL first_edge_valid: got %b expected 0", periodValid); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL first_edge_locked: got %b expected 0", locked); end
    pulseIn = 1'b0; tick(97);
    for (int i = 0; i < 4; i++) begin
      pulseIn = 1'b1; tick(3);
      tests++; if (periodValid !== 1'b1) begin fails++; $display("FAIL steady_valid[%0d]: got %b expected 1", i, periodValid); end
      tests++; if (periodOut !== 16'd100) begin fails++; $display("FAIL steady_period[%0d]: got %0d expected 100", i, periodOut); end
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL steady_locked[%0d]: got %b expected 1", i, locked); end
      pulseIn = 1'b0; tick(97);
    end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL steady_timeout: got %b expected 0", timeout); end
  endtask

  task automatic test_glitch;
    int vc0;
    vc0 = valid_count;
    pulseIn = 1'b1; tick(1);
    pulseIn = 1'b0; tick(1);
    pulseIn = 1'b1; tick(1);
    tests++; if (periodValid !== 1'b1 || periodOut !== 16'd100) begin fails++; $display("FAIL glitch_pre_edge: got valid=%b period=%0d expected valid=1 period=100", periodValid, periodOut); end
    pulseIn = 1'b0; tick(47);
    pulseIn = 1'b1; tick(3);
    tests++; if (periodValid !== 1'b1) begin fails++; $display("FAIL glitch_valid: got %b expected 1", periodValid); end
    tests++; if (periodOut !== 16'd50) begin fails++; $display("FAIL glitch_period: got %0d expected 50", periodOut); end
    pulseIn = 1'b0; tick(1);
    tests++; if (valid_count - vc0 !== 2) begin fails++; $display("FAIL glitch_valid_count: got %0d expected 2", valid_count - vc0); end
    tests++; if (periodValid !== 1'b0) begin fails++; $display("FAIL glitch_strobe_width: got %b expected 0", periodValid); end
    tick(46);
    pulseIn = 1'b1; tick(3);
    tests++; if (periodOut !== 16'd50) begin fails++; $display("FAIL glitch_second_period: got %0d expected 50", periodOut); end
    pulseIn = 1'b0; tick(97);
  endtask

  task automatic test_timeout;
    pulseIn = 1'b1; tick(3);
    tests++; if (periodValid !== 1'b1 || periodOut !== 16'd100) begin fails++; $display("FAIL timeout_last_edge: got valid=%b period=%0d expected valid=1 period=100", periodValid, periodOut); end
    pulseIn = 1'b0; tick(999);
    tests++; if (timeout !== 1'b0 || locked !== 1'b1) begin fails++; $display("FAIL timeout_early: got timeout=%b locked=%b expected timeout=0 locked=1", timeout, locked); end
    tick(1);
    tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL timeout_set: got %b expected 1", timeout); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL timeout_locked: got %b expected 0", locked); end
    tests++; if (periodOut !== 16'd100) begin fails++; $display("FAIL timeout_hold: got %0d expected 100", periodOut); end
    tick(20);
    pulseIn = 1'b1; tick(3);
    tests++; if (timeout !== 1'b0 || periodValid !== 1'b0) begin fails++; $display("FAIL timeout_exit: got timeout=%b valid=%b expected 0 0", timeout, periodValid); end
    pulseIn = 1'b0; tick(27);
    pulseIn = 1'b1; tick(3);
    tests++; if (periodValid !== 1'b1 || periodOut !== 16'd30) begin fails++; $display("FAIL timeout_recover: got valid=%b period=%0d expected valid=1 period=30", periodValid, periodOut); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL timeout_relock: got %b expected 1", locked); end
  endtask

  task automatic test_boundary;
    pulseIn = 1'b0; tick(997);
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL boundary_pre_timeout: got %b expected 0", timeout); end
    pulseIn = 1'b1; tick(3);
    tests++; if (periodValid !== 1'b1) begin fails++; $display("FAIL boundary_valid: got %b expected 1", periodValid); end
    tests++; if (periodOut !== 16'd1000) begin fails++; $display("FAIL boundary_period: got %0d expected 1000", periodOut); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL boundary_timeout: got %b expected 0", timeout); end
    pulseIn = 1'b0; tick(1);
    tests++; if (timeout !== 1'b0 || locked !== 1'b1) begin fails++; $display("FAIL boundary_after: got timeout=%b locked=%b expected 0 1", timeout, locked); end
  endtask

  task automatic test_reset_mid;
    tick(96);
    pulseIn = 1'b1; tick(3);
    tests++; if (periodValid !== 1'b1 || periodOut !== 16'd100) begin fails++; $display("FAIL midrst_setup: got valid=%b period=%0d expected valid=1 period=100", periodValid, periodOut); end
    pulseIn = 1'b0; tick(37);
    rst = 1'b1;
    #1;
    tests++; if (periodOut !== 16'd0 || periodValid !== 1'b0 || timeout !== 1'b0 || locked !== 1'b0) begin fails++; $display("FAIL midrst_outputs: got period=%0d valid=%b timeout=%b locked=%b expected all 0", periodOut, periodValid, timeout, locked); end
    tick(2);
    rst = 1'b0;
    tick(5);
    pulseIn = 1'b1; tick(3);
    tests++; if (periodValid !== 1'b0 || locked !== 1'b0) begin fails++; $display("FAIL midrst_first_edge: got valid=%b locked=%b expected 0 0", periodValid, locked); end
    pulseIn = 1'b0; tick(97);
    pulseIn = 1'b1; tick(3);
    tests++; if (periodValid !== 1'b1 || periodOut !== 16'd100) begin fails++; $display("FAIL midrst_second_edge: got valid=%b period=%0d expected valid=1 period=100", periodValid, periodOut); end
    pulseIn = 1'b0; tick(10);
  endtask

  task automatic test_disable;
    enable = 1'b0; tick(1);
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL disable_locked: got %b expected 0", locked); end
    tests++; if (periodOut !== 16'd100) begin fails++; $display("FAIL disable_hold: got %0d expected 100", periodOut); end
    tick(9);
    enable = 1'b1; tick(5);
    pulseIn = 1'b1; tick(3);
    tests++; if (periodValid !== 1'b0 || periodOut !== 16'd100) begin fails++; $display("FAIL disable_first_edge: got valid=%b period=%0d expected valid=0 period=100", periodValid, periodOut); end
    pulseIn = 1'b0; tick(57);
    pulseIn = 1'b1; tick(3);
    tests++; if (periodValid !== 1'b1 || periodOut !== 16'd60 || locked !== 1'b1) begin fails++; $display("FAIL disable_rearm: got valid=%b period=%0d locked=%b expected 1 60 1", periodValid, periodOut, locked); end
    pulseIn = 1'b0; tick(2);
  endtask

  initial begin
    test_reset();
    test_steady();
    test_glitch();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_disable();
    tests++; if (back_to_back !== 0) begin fails++; $display("FAIL strobe_back_to_back: got %0d expected 0", back_to_back); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
